// File: rtl/cla_adder_bist_pkg.sv
// Shared definitions for the CLA adder self-test: FSM encoding, sweep
// sizing constants and the layout of the {a,b,cin} vector.
package cla_adder_bist_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Exhaustive sweep of 4-bit a, 4-bit b and cin
    localparam int NUM_VEC_DEFAULT = 512;

    // Width of the mismatch counter and its saturation value
    localparam int             ERR_W   = 10;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Vector index width and operand/result widths
    localparam int VEC_W  = 9;
    localparam int OPND_W = 4;
    localparam int SUM_W  = 5;

    // Field offsets inside the vector index {a[3:0], b[3:0], cin}
    localparam int CIN_OFS = 0;
    localparam int B_OFS   = 1;
    localparam int A_OFS   = 5;

endpackage

// File: rtl/cla_adder_bist_cla.sv
// 4-bit carry-look-ahead adder. Carries are produced directly from the
// generate/propagate terms so no carry ripples between bit positions.
module carry_look_ahead_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] carry;

    // Per-bit generate/propagate, flattened look-ahead carries and sum bits
    always_comb begin
        gen   = a & b;
        prop  = a ^ b;
        carry[0] = cin;
        carry[1] = gen[0] | (prop[0] & cin);
        carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
        carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & cin);
        carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0])
                 | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
        sum  = prop ^ carry[3:0];
        cout = carry[4];
    end

endmodule

// File: rtl/cla_adder_bist.sv
// Built-in self-test for the 4-bit CLA adder. Walks every {a,b,cin}
// combination through the adder, captures each result one cycle later and
// compares it against a behavioural sum, tracking how many vectors failed
// and which one failed first.
module cla_adder_bist
    import cla_adder_bist_pkg::*;
#(
    parameter int NUM_VEC = NUM_VEC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inject_fault,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               cap_valid_q, cap_valid_d;
    logic [VEC_W-1:0]   cap_vec_q, cap_vec_d;
    logic [SUM_W-1:0]   cap_sum_q, cap_sum_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               ffv_q, ffv_d;
    logic [VEC_W-1:0]   ffvec_q, ffvec_d;

    logic               accept_start;
    logic [OPND_W-1:0]  op_a;
    logic [OPND_W-1:0]  op_b;
    logic               op_cin;
    logic [OPND_W-1:0]  adder_sum;
    logic               adder_cout;
    logic [SUM_W-1:0]   expected_sum;
    logic               mismatch;

    // Adder under test is fed straight from the registered vector counter
    assign op_a   = vec_q[A_OFS +: OPND_W];
    assign op_b   = vec_q[B_OFS +: OPND_W];
    assign op_cin = vec_q[CIN_OFS];

    carry_look_ahead_adder u_cla (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    // Reference sum recomputed from the captured vector, and the mismatch flag
    always_comb begin
        expected_sum = {1'b0, cap_vec_q[A_OFS +: OPND_W]}
                     + {1'b0, cap_vec_q[B_OFS +: OPND_W]}
                     + {{(SUM_W-1){1'b0}}, cap_vec_q[CIN_OFS]};
        mismatch     = cap_valid_q && (cap_sum_q != expected_sum);
    end

    // A new sweep may only begin from a finished or idle controller
    assign accept_start = start && ((state_q == IDLE) || (state_q == DONE));

    // Sweep controller next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (vec_q == LAST_VEC) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Vector walk, result capture and error bookkeeping
    always_comb begin
        vec_d       = vec_q;
        cap_valid_d = 1'b0;
        cap_vec_d   = cap_vec_q;
        cap_sum_d   = cap_sum_q;
        err_count_d = err_count_q;
        ffv_d       = ffv_q;
        ffvec_d     = ffvec_q;

        // The capture stage is checked whenever it holds a fresh result
        if (mismatch) begin
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
            end
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = cap_vec_q;
            end
        end

        if (accept_start) begin
            vec_d       = '0;
            err_count_d = '0;
            ffv_d       = 1'b0;
            ffvec_d     = '0;
        end else if (state_q == RUN) begin
            // The fault hook corrupts only what is captured this cycle
            cap_valid_d = 1'b1;
            cap_vec_d   = vec_q;
            cap_sum_d   = {adder_cout, adder_sum} ^ {{(SUM_W-1){1'b0}}, inject_fault};
            if (vec_q != LAST_VEC) begin
                vec_d = vec_q + 1'b1;
            end
        end
    end

    // State and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_vec_q   <= '0;
            cap_sum_q   <= '0;
            err_count_q <= '0;
            ffv_q       <= 1'b0;
            ffvec_q     <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cap_valid_q <= cap_valid_d;
            cap_vec_q   <= cap_vec_d;
            cap_sum_q   <= cap_sum_d;
            err_count_q <= err_count_d;
            ffv_q       <= ffv_d;
            ffvec_q     <= ffvec_d;
        end
    end

    // Status outputs decoded from the controller state
    always_comb begin
        busy             = (state_q == RUN) || (state_q == DRAIN);
        done             = (state_q == DONE);
        pass             = (state_q == DONE) && (err_count_q == '0);
        err_count        = err_count_q;
        first_fail_valid = ffv_q;
        first_fail_vec   = ffvec_q;
    end

endmodule

// File: tb/tb_cla_adder_bist.sv
// Directed bench for cla_adder_bist: clean sweeps, injected faults, restart
// behaviour and asynchronous reset, with hand-derived expectations.
module tb_cla_adder_bist;

    logic       clk;
    logic       rst;
    logic       start;
    logic       inject_fault;
    logic       busy;
    logic       done;
    logic       pass;
    logic [9:0] err_count;
    logic       first_fail_valid;
    logic [8:0] first_fail_vec;

    int assertCount;
    int failCount;
    int doneEdge;
    int busyCycles;

    cla_adder_bist dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .inject_fault     (inject_fault),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one sweep from a negedge. inject_fault is high for the cycles
    // following edges faultOn..faultOff-1; a stray start is raised in the
    // cycle following edge startAgainAt (-1 for none).
    task automatic applyStimulus(input string tag, input int faultOn, input int faultOff,
                                 input int startAgainAt,
                                 output int edgeOfDone, output int busyCount);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, "_acceptBusy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_acceptDone"}, 32'(done), 32'd0);
        checkOutput({tag, "_acceptErr"}, 32'(err_count), 32'd0);
        checkOutput({tag, "_acceptFfv"}, 32'(first_fail_valid), 32'd0);
        busyCount    = busy ? 1 : 0;
        edgeOfDone   = -1;
        inject_fault = (0 >= faultOn) && (0 < faultOff);
        for (int e = 1; e < 600 && edgeOfDone < 0; e++) begin
            @(posedge clk);
            #1;
            if (busy) busyCount++;
            if (done) edgeOfDone = e;
            inject_fault = (e >= faultOn) && (e < faultOff);
            start        = (e == startAgainAt);
        end
        start        = 1'b0;
        inject_fault = 1'b0;
        @(negedge clk);
    endtask

    // Final result checks of a completed sweep
    task automatic checkSweep(input string tag, input int edgeOfDone, input int busyCount,
                              input int expErr, input int expFfv, input int expVec);
        checkOutput({tag, "_doneEdge"}, 32'(edgeOfDone), 32'd513);
        checkOutput({tag, "_busyCycles"}, 32'(busyCount), 32'd513);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), (expErr == 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_errCount"}, 32'(err_count), 32'(expErr));
        checkOutput({tag, "_ffValid"}, 32'(first_fail_valid), 32'(expFfv));
        checkOutput({tag, "_ffVec"}, 32'(first_fail_vec), 32'(expVec));
    endtask

    initial begin
        assertCount  = 0;
        failCount    = 0;
        rst          = 1'b1;
        start        = 1'b0;
        inject_fault = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_err", 32'(err_count), 32'd0);
        checkOutput("rst_ffv", 32'(first_fail_valid), 32'd0);
        checkOutput("rst_ffvec", 32'(first_fail_vec), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean sweep
        $display("[TB] clean sweep");
        applyStimulus("clean", 1000, 0, -1, doneEdge, busyCycles);
        checkSweep("clean", doneEdge, busyCycles, 0, 0, 0);

        // done and pass are held while idle in DONE
        repeat (5) @(negedge clk);
        checkOutput("hold_done", 32'(done), 32'd1);
        checkOutput("hold_pass", 32'(pass), 32'd1);

        // Fault injected on every vector
        $display("[TB] fault on all vectors");
        applyStimulus("allFault", 0, 1000, -1, doneEdge, busyCycles);
        checkSweep("allFault", doneEdge, busyCycles, 512, 1, 0);

        // Restart from DONE after a failing sweep clears the results
        $display("[TB] restart after failing sweep");
        applyStimulus("restart", 1000, 0, -1, doneEdge, busyCycles);
        checkSweep("restart", doneEdge, busyCycles, 0, 0, 0);

        // Fault only while vector 0x0A5 is captured
        $display("[TB] single-vector fault");
        applyStimulus("oneFault", 165, 166, -1, doneEdge, busyCycles);
        checkSweep("oneFault", doneEdge, busyCycles, 1, 1, 9'h0A5);

        // start while busy is ignored
        $display("[TB] start while busy");
        applyStimulus("busyStart", 1000, 0, 100, doneEdge, busyCycles);
        checkSweep("busyStart", doneEdge, busyCycles, 0, 0, 0);

        // Asynchronous reset mid-sweep with errors already counted
        $display("[TB] reset mid-sweep");
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        inject_fault = 1'b1;
        repeat (200) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_pass", 32'(pass), 32'd0);
        checkOutput("abort_err", 32'(err_count), 32'd0);
        checkOutput("abort_ffv", 32'(first_fail_valid), 32'd0);
        checkOutput("abort_ffvec", 32'(first_fail_vec), 32'd0);
        inject_fault = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus("postRst", 1000, 0, -1, doneEdge, busyCycles);
        checkSweep("postRst", doneEdge, busyCycles, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
